// File: rtl/accum_ctrl_pkg.sv
// Shared types and constants for the MVM accumulator sequencer.
package accum_ctrl_pkg;

  // Width of the row, partial and gap counters.
  localparam int unsigned CntW = 8;

  // Default minimum spacing between accumulator issues.
  localparam int unsigned DefIssueGap = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StGap   = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/accum_ctrl_fifo.sv
// Small synchronous FIFO. Head is read combinationally; push while full is
// accepted only when a pop happens in the same cycle.
module accum_ctrl_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates the head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/accum_ctrl.sv
// Sequencer for the MVM output accumulator: meters partial sums into the
// accumulator, collects row results in order and hands them downstream
// under credit control so no returned row is ever dropped.
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int unsigned DATAW     = 32,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDRW     = $clog2(DEPTH),
  parameter int unsigned ISSUE_GAP = DefIssueGap,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDRW-1:0] cmd_base,
  input  logic [CntW-1:0]  cmd_rows,
  input  logic [CntW-1:0]  cmd_nvalids,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             acc_valid,
  output logic [DATAW-1:0] acc_data,
  output logic [ADDRW-1:0] acc_addr,
  output logic             acc_accum,
  output logic             acc_last,
  output logic [CntW-1:0]  acc_nvalids,
  input  logic             acc_rvalid,
  input  logic [DATAW-1:0] acc_rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DATAW-1:0] res_data,
  output logic [ADDRW-1:0] res_addr,
  output logic             res_last,
  output logic             done,
  output logic             err
);

  localparam int unsigned EntW = DATAW + ADDRW + 1;
  localparam int unsigned CrW  = $clog2(RES_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic [CntW-1:0]  rows_q, rows_d, n_q, n_d;
  logic [CntW-1:0]  r_q, r_d, k_q, k_d, rr_q, rr_d, gap_q, gap_d;
  // out: rows issued but not yet returned; used: out plus buffered rows.
  logic [CrW-1:0]   out_q, out_d, used_q, used_d;
  logic             err_q, err_d, done_q, done_d;
  logic             acc_valid_q, acc_valid_d, acc_accum_q, acc_accum_d;
  logic             acc_last_q, acc_last_d;
  logic [DATAW-1:0] acc_data_q, acc_data_d;
  logic [ADDRW-1:0] acc_addr_q, acc_addr_d;

  logic             hs, k_last, row_last, row_done, rv_ok, pop, credit_ok;
  logic             fifo_empty, fifo_full;
  logic [EntW-1:0]  fifo_wdata, fifo_rdata;

  function automatic logic [ADDRW-1:0] row_addr(input logic [ADDRW-1:0] b,
                                                input logic [CntW-1:0]  r);
    return ADDRW'((32'(b) + 32'(r)) % DEPTH);
  endfunction

  assign hs        = in_valid && in_ready;
  assign k_last    = (k_q == n_q - 1'b1);
  assign row_last  = (r_q == rows_q - 1'b1);
  assign row_done  = hs && k_last;
  assign rv_ok     = acc_rvalid && (out_q != '0);
  assign pop       = res_valid && res_ready;
  assign credit_ok = (used_q < CrW'(RES_DEPTH)) && !fifo_full;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = (cmd_rows == '0 || cmd_nvalids == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (hs) begin
          if (k_last && row_last) state_d = StDrain;
          else if (ISSUE_GAP > 1) state_d = StGap;
        end
      end
      StGap:   if (gap_q == CntW'(ISSUE_GAP - 2)) state_d = StIssue;
      StDrain: if (out_q == '0 && fifo_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; a new row may only start while a result slot is reserved.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    in_ready  = (state_q == StIssue) && ((k_q != '0) || credit_ok);
  end

  // Datapath next-state: command latch, issue registers, counters.
  always_comb begin
    base_d      = base_q;
    rows_d      = rows_q;
    n_d         = n_q;
    r_d         = r_q;
    k_d         = k_q;
    rr_d        = rr_q;
    gap_d       = gap_q;
    err_d       = err_q;
    done_d      = 1'b0;
    acc_valid_d = 1'b0;
    acc_data_d  = acc_data_q;
    acc_addr_d  = acc_addr_q;
    acc_accum_d = acc_accum_q;
    acc_last_d  = acc_last_q;
    if (state_q == StIdle && cmd_valid) begin
      base_d = cmd_base;
      rows_d = cmd_rows;
      n_d    = cmd_nvalids;
      r_d    = '0;
      k_d    = '0;
      rr_d   = '0;
    end
    if (hs) begin
      acc_valid_d = 1'b1;
      acc_data_d  = in_data;
      acc_addr_d  = row_addr(base_q, r_q);
      acc_accum_d = (k_q != '0);
      acc_last_d  = k_last;
      gap_d       = '0;
      if (k_last) begin
        k_d = '0;
        r_d = r_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
    if (state_q == StGap) gap_d = gap_q + 1'b1;
    out_d  = out_q + CrW'(row_done) - CrW'(rv_ok);
    used_d = used_q + CrW'(row_done) - CrW'(pop);
    if (rv_ok) rr_d = rr_q + 1'b1;
    if (acc_rvalid && out_q == '0) err_d = 1'b1;
    if (state_q == StDrain && state_d == StIdle) done_d = 1'b1;
  end

  // Datapath state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      rows_q      <= '0;
      n_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      rr_q        <= '0;
      gap_q       <= '0;
      out_q       <= '0;
      used_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_data_q  <= '0;
      acc_addr_q  <= '0;
      acc_accum_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      base_q      <= base_d;
      rows_q      <= rows_d;
      n_q         <= n_d;
      r_q         <= r_d;
      k_q         <= k_d;
      rr_q        <= rr_d;
      gap_q       <= gap_d;
      out_q       <= out_d;
      used_q      <= used_d;
      err_q       <= err_d;
      done_q      <= done_d;
      acc_valid_q <= acc_valid_d;
      acc_data_q  <= acc_data_d;
      acc_addr_q  <= acc_addr_d;
      acc_accum_q <= acc_accum_d;
      acc_last_q  <= acc_last_d;
    end
  end

  assign fifo_wdata = {acc_rdata, row_addr(base_q, rr_q), rr_q == rows_q - 1'b1};

  accum_ctrl_fifo #(
    .Width (EntW),
    .Depth (RES_DEPTH)
  ) u_res_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (rv_ok),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign res_valid                    = !fifo_empty;
  assign {res_data, res_addr, res_last} = fifo_rdata;

  assign acc_valid   = acc_valid_q;
  assign acc_data    = acc_data_q;
  assign acc_addr    = acc_addr_q;
  assign acc_accum   = acc_accum_q;
  assign acc_last    = acc_last_q;
  assign acc_nvalids = n_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl with a behavioural accumulator and
// scoreboard queues for issues and row results.
module tb_accum_ctrl;

  localparam int DATAW = 32;
  localparam int DEPTH = 512;
  localparam int ADDRW = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ADDRW-1:0] cmd_base = '0;
  logic [7:0]       cmd_rows = '0;
  logic [7:0]       cmd_nvalids = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DATAW-1:0] in_data = '0;
  logic             acc_valid;
  logic [DATAW-1:0] acc_data;
  logic [ADDRW-1:0] acc_addr;
  logic             acc_accum;
  logic             acc_last;
  logic [7:0]       acc_nvalids;
  logic             acc_rvalid = 1'b0;
  logic [DATAW-1:0] acc_rdata = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [DATAW-1:0] res_data;
  logic [ADDRW-1:0] res_addr;
  logic             res_last;
  logic             done;
  logic             err;

  accum_ctrl #(
    .DATAW     (DATAW),
    .DEPTH     (DEPTH),
    .ADDRW     (ADDRW),
    .ISSUE_GAP (5),
    .RES_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_base    (cmd_base),
    .cmd_rows    (cmd_rows),
    .cmd_nvalids (cmd_nvalids),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .acc_valid   (acc_valid),
    .acc_data    (acc_data),
    .acc_addr    (acc_addr),
    .acc_accum   (acc_accum),
    .acc_last    (acc_last),
    .acc_nvalids (acc_nvalids),
    .acc_rvalid  (acc_rvalid),
    .acc_rdata   (acc_rdata),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_addr    (res_addr),
    .res_last    (res_last),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [8:0]  addr;
    logic        accum;
    logic        last;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic [8:0]  addr;
    logic        last;
  } res_t;

  acc_t        exp_acc[$];
  res_t        exp_res[$];
  logic [31:0] in_q[$];
  int          ret_cnt[$];
  logic [31:0] ret_val[$];

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int done_cnt = 0;
  int spur_cnt = 0;
  int spur_done = 0;
  int cmd_seq = 0;
  int seen_seq = 0;
  int last_acc_cyc = 0;
  bit chk_spacing = 1'b0;
  bit hs_flag = 1'b0;
  logic [31:0] msum = '0;
  acc_t mon_a;
  res_t mon_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Partial-sum source: presents the queue head, retires it after a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      hs_flag  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
    end else begin
      if (hs_flag && in_q.size() > 0) void'(in_q.pop_front());
      in_valid = (in_q.size() > 0);
      in_data  = in_valid ? in_q[0] : '0;
      hs_flag  = in_valid && in_ready;
    end
  end

  // Accumulator model plus issue/result/done monitors.
  always @(negedge clk) begin
    acc_rvalid = 1'b0;
    acc_rdata  = '0;
    if (!rst) begin
      ret_cnt.delete();
      ret_val.delete();
      msum = '0;
    end else begin
      foreach (ret_cnt[i]) ret_cnt[i]--;
      if (ret_cnt.size() > 0 && ret_cnt[0] == 0) begin
        acc_rvalid = 1'b1;
        acc_rdata  = ret_val[0];
        void'(ret_cnt.pop_front());
        void'(ret_val.pop_front());
      end else if (spur_done != spur_cnt) begin
        acc_rvalid = 1'b1;
        acc_rdata  = 32'hdead_beef;
        spur_done++;
      end
      if (acc_valid) begin
        issue_cnt++;
        if (exp_acc.size() == 0) begin
          check("acc_unexpected", 1, 0);
        end else begin
          mon_a = exp_acc.pop_front();
          check("acc_data", acc_data, mon_a.data);
          check("acc_addr", acc_addr, mon_a.addr);
          check("acc_accum", acc_accum, mon_a.accum);
          check("acc_last", acc_last, mon_a.last);
        end
        if (cmd_seq != seen_seq) seen_seq = cmd_seq;
        else if (chk_spacing) check("acc_spacing", cyc - last_acc_cyc, 5);
        last_acc_cyc = cyc;
        msum = acc_accum ? msum + acc_data : acc_data;
        if (acc_last) begin
          ret_cnt.push_back(4);
          ret_val.push_back(msum);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          mon_r = exp_res.pop_front();
          check("res_data", res_data, mon_r.data);
          check("res_addr", res_addr, mon_r.addr);
          check("res_last", res_last, mon_r.last);
        end
      end
      if (done) done_cnt++;
    end
  end

  // Queues the expected traffic for a command, then offers it for one cycle.
  task automatic send_cmd(input int base, input int rows, input int nv);
    acc_t        a;
    res_t        r;
    logic [31:0] sum;
    for (int ri = 0; ri < rows; ri++) begin
      sum = '0;
      for (int ki = 0; ki < nv; ki++) begin
        a.data  = 32'(ri * nv + ki + 1);
        a.addr  = 9'((base + ri) % DEPTH);
        a.accum = (ki != 0);
        a.last  = (ki == nv - 1);
        in_q.push_back(a.data);
        exp_acc.push_back(a);
        sum = sum + a.data;
      end
      r.data = sum;
      r.addr = 9'((base + ri) % DEPTH);
      r.last = (ri == rows - 1);
      if (nv != 0) exp_res.push_back(r);
    end
    cmd_seq++;
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_base    = 9'(base);
    cmd_rows    = 8'(rows);
    cmd_nvalids = 8'(nv);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check({tag, "_cmd_ready_at_done"}, cmd_ready, 1);
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int i0, d0, lat;
    bit saw;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_acc_nvalids", acc_nvalids, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic command: two rows of three partials.
    chk_spacing = 1'b1;
    i0 = issue_cnt;
    d0 = done_cnt;
    send_cmd(0, 2, 3);
    check("basic_nvalids", acc_nvalids, 3);
    wait_done("basic", 200);
    chk_spacing = 1'b0;
    check("basic_issues", issue_cnt - i0, 6);
    check("basic_acc_left", exp_acc.size(), 0);
    check("basic_res_left", exp_res.size(), 0);
    repeat (3) @(negedge clk);
    check("basic_done_once", done_cnt - d0, 1);

    // Address wrap-around.
    i0 = issue_cnt;
    send_cmd(510, 4, 1);
    wait_done("wrap", 200);
    check("wrap_issues", issue_cnt - i0, 4);
    check("wrap_res_left", exp_res.size(), 0);

    // Backpressure: credits stop issue after four rows.
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    i0 = issue_cnt;
    d0 = done_cnt;
    send_cmd(0, 8, 1);
    repeat (60) @(negedge clk);
    check("bp_issues_stalled", issue_cnt - i0, 4);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_res_valid", res_valid, 1);
    check("bp_res_head", res_data, 1);
    check("bp_res_pending", exp_res.size(), 8);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_done("bp", 300);
    check("bp_issues_total", issue_cnt - i0, 8);
    check("bp_res_left", exp_res.size(), 0);
    repeat (3) @(negedge clk);
    check("bp_done_once", done_cnt - d0, 1);

    // Zero-size command.
    i0 = issue_cnt;
    send_cmd(0, 0, 5);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      if (done) begin
        lat = i;
        check("zero_cmd_ready_at_done", cmd_ready, 1);
        break;
      end
      @(negedge clk);
    end
    check("zero_done_latency_ok", (lat >= 1 && lat <= 2), 1);
    repeat (3) @(negedge clk);
    check("zero_no_issue", issue_cnt - i0, 0);
    check("zero_cmd_ready", cmd_ready, 1);

    // Spurious result while idle.
    spur_cnt++;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw |= res_valid;
    end
    check("spur_err_set", err, 1);
    check("spur_no_res", saw, 0);
    repeat (10) @(negedge clk);
    check("spur_err_sticky", err, 1);

    // Reset in the middle of a command.
    i0 = issue_cnt;
    send_cmd(0, 4, 2);
    for (int i = 0; i < 100 && (issue_cnt - i0) < 3; i++) @(negedge clk);
    check("mid_three_issues", issue_cnt - i0, 3);
    @(posedge clk);
    #2 rst = 1'b0;
    in_q.delete();
    exp_acc.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_in_ready", in_ready, 0);
    check("mid_acc_valid", acc_valid, 0);
    check("mid_acc_addr", acc_addr, 0);
    check("mid_res_valid", res_valid, 0);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    check("mid_acc_nvalids", acc_nvalids, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    i0 = issue_cnt;
    send_cmd(5, 2, 2);
    wait_done("post_rst", 200);
    check("post_rst_issues", issue_cnt - i0, 4);
    check("post_rst_res_left", exp_res.size(), 0);
    check("post_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Sequencer for the MVM output accumulator. It accepts a reduction command, meaning R rows with N partial sums per row, starting at a base address. It meters the partial-sum stream into the accumulator at the issue rate the accumulator can sustain, generating address, accumulate and last flags. It collects the finished row results in order and presents them downstream with valid/ready backpressure, using credits so that no accumulator result is ever lost.

## Interface
- DATAW, 32, partial-sum/result width
- DEPTH, 512, accumulator memory depth
- ADDRW, $clog2(DEPTH), accumulator address width
- ISSUE_GAP, 5, minimum cycles between consecutive accumulator issues (≥1)
- RES_DEPTH, 4, result buffer entries, which is also the row credit count
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle and accepting a command
- cmd_base  in  ADDRW  first row address
- cmd_rows  in  8  rows R
- cmd_nvalids  in  8  partials per row N
- in_valid  in  1  partial-sum available
- in_ready  out  1  partial-sum accepted this cycle
- in_data  in  DATAW  partial sum
- acc_valid  out  1  issue to accumulator (one-cycle pulse)
- acc_data  out  DATAW  partial sum issued
- acc_addr  out  ADDRW  row address issued
- acc_accum  out  1  0 = overwrite, 1 = add to stored value
- acc_last  out  1  final partial of row
- acc_nvalids  out  8  N of the current command, held stable for the whole command
- acc_rvalid  in  1  accumulator row result valid
- acc_rdata  in  DATAW  accumulator row result
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  DATAW  row result
- res_addr  out  ADDRW  row address of result
- res_last  out  1  final row of command
- done  out  1  one-cycle pulse when the command is complete
- err  out  1  sticky: unexpected acc_rvalid received

## Operation
- The FSM has four states: IDLE, ISSUE, GAP, DRAIN.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid, latch base/R/N, clear the row counter r and partial counter k, and go to ISSUE.
  - If R==0 or N==0, go to DRAIN instead; done is then pulsed with no issue.
- **ISSUE:**
  - in_ready=1 only if k≠0, or the credit condition holds: (rows issued-but-unreturned + buffer occupancy) < RES_DEPTH.
  - On in_valid&&in_ready, register acc_data=in_data, acc_addr=(base+r) mod DEPTH, acc_accum=(k≠0), acc_last=(k==N-1), and acc_valid=1.
  - Then advance k. When k wraps, advance r, and increment outstanding.
  - Go to GAP, or to DRAIN if that was row R-1's last partial.
- **GAP:**
  - in_ready=0; count ISSUE_GAP-1 cycles, then go to ISSUE.
  - If ISSUE_GAP==1, GAP lasts 0 cycles and the next cycle is ISSUE.
- **DRAIN:**
  - in_ready=0; wait until outstanding==0 and the result buffer is empty.
  - Then pulse done and go to IDLE.
- **Result path:**
  - Each acc_rvalid pushes {acc_rdata, row address, last flag} into the result buffer and decrements outstanding.
  - Row address is (base + returned-row counter) mod DEPTH; the last flag is returned-row==R-1.
  - Results return in issue order.
  - If acc_rvalid arrives while outstanding==0: drop the result, set err; err clears only on reset.
- The buffer head drives res_*. A pop occurs on res_valid&&res_ready.
- A simultaneous push and pop is allowed in the same cycle, including when the buffer is full.
- Address arithmetic wraps modulo DEPTH (base=510, R=4 → 510, 511, 0, 1).

## Timing
- Reset values: cmd_ready=1; all other outputs 0; state IDLE; all counters 0.
- Asserting rst mid-command aborts it immediately and discards buffered results.
- Command acceptance to the first possible in_ready: 1 cycle.
- in handshake to acc_valid: 1 cycle (registered). acc_* fields are valid only while acc_valid=1.
- Issue spacing: ≥ ISSUE_GAP cycles between acc_valid pulses.
- acc_rvalid to res_valid: 1 cycle (registered buffer).
- res_* hold stable while res_valid&&!res_ready.
- done asserts one cycle after the last result is popped. cmd_ready rises in the same cycle as done.

## Structure
- Package accum_ctrl_pkg: FSM state enum (IDLE/ISSUE/GAP/DRAIN), count width constant (8), and default ISSUE_GAP.
- Sub-module: the existing fifo, instantiated as the result buffer.
  - Data width: DATAW+ADDRW+1.
  - Depth: RES_DEPTH.
  - Its empty/full outputs feed the credit logic.
- The credit counter is internal, width $clog2(RES_DEPTH)+1.

## Test plan
- **Basic command:** base=0, R=2, N=3, in_valid always 1, res_ready=1, accumulator model returns the sum 4 cycles after acc_last.
  - acc_accum pattern 0,1,1,0,1,1; acc_last on issues 3 and 6.
  - acc_valid spacing is exactly 5 cycles.
  - Results (addr 0 = 1+2+3 = 6, last=0) then (addr 1 = 15, last=1); done follows.
- **Wrap-around:** base=510, R=4, N=1 → acc_addr 510, 511, 0, 1, each with acc_accum=0 and acc_last=1.
- **Backpressure:** R=8, N=1, res_ready=0.
  - Exactly 4 rows issue, then in_ready stays 0.
  - Raising res_ready resumes issue; all 8 results arrive in order and done fires once.
- **Zero-size command:** R=0, N=5 → no acc_valid, done 1–2 cycles after acceptance, cmd_ready back to 1.
- **Spurious result:** acc_rvalid pulse while IDLE → err=1 and stays set, no res_valid.
- **Mid-command reset:** rst low after 3 issues of R=4, N=2.
  - All outputs return to reset values; cmd_ready=1.
  - A new command then runs cleanly.
